// File: rtl/matmul_controller_if.sv
// ============================================================================
// Module      : matmul_controller_if
// Description : Valid/ready word stream (data + last) used for the matrix
//               source and result streams of matmul_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_controller_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/matmul_controller.sv
// ============================================================================
// Module      : matmul_controller
// Description : Loads two NxN matrices from a source stream into RAM A/B,
//               computes C = A*B with one MAC per cycle into RAM C, then
//               streams C out row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_controller #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic                CLK,
  input  logic                RESET,
  matmul_controller_if.slave  s_axis,
  matmul_controller_if.master m_axis,
  output logic [AW-1:0]       address_a,
  output logic [AW-1:0]       address_b,
  output logic [AW-1:0]       address_c,
  output logic [DW-1:0]       write_data_a,
  output logic [DW-1:0]       write_data_b,
  output logic [DW-1:0]       write_data_c,
  output logic                write_en_a,
  output logic                write_en_b,
  output logic                write_en_c,
  input  logic [DW-1:0]       read_data_a,
  input  logic [DW-1:0]       read_data_b,
  input  logic [DW-1:0]       read_data_c,
  output logic                busy,
  output logic                err
);

  localparam int NN = N * N;
  // One spare bit so the terminal count never wraps.
  localparam int CW = $clog2(NN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);
  localparam logic [CW-1:0] K_END    = CW'(N);
  localparam logic [CW-1:0] N_C      = CW'(N);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    MAC    = 3'd3,
    WR_C   = 3'd4,
    RD_C   = 3'd5,
    STREAM = 3'd6
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] i_cnt;
  logic [CW-1:0] j_cnt;
  logic [CW-1:0] k_cnt;
  logic [CW-1:0] out_cnt;
  logic [DW-1:0] acc;
  logic [DW-1:0] hold_data;
  logic          s_ready;
  logic          first_cycle;
  logic          s_beat;
  logic          m_beat;
  logic          last_b_word;

  assign s_axis.ready  = s_ready;
  assign s_beat        = s_axis.valid && s_ready;
  assign m_beat        = (state == STREAM) && m_axis.ready;
  assign last_b_word   = (state == LOAD_B) && (load_cnt == LAST_IDX);

  assign m_axis.valid  = (state == STREAM);
  assign m_axis.last   = (state == STREAM) && (out_cnt == LAST_IDX);
  // The RAM word arrives in the first STREAM cycle; later stall cycles use
  // the captured copy so DATA stays stable while the sink holds off.
  assign m_axis.data   = first_cycle ? read_data_c : hold_data;
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_beat) state_next = LOAD_A;
      LOAD_A:  if (s_beat && load_cnt == LAST_IDX) state_next = LOAD_B;
      LOAD_B:  if (s_beat && load_cnt == LAST_IDX) state_next = MAC;
      MAC:     if (k_cnt == K_END) state_next = WR_C;
      WR_C:    state_next = (i_cnt == LAST_ROW && j_cnt == LAST_ROW) ? RD_C : MAC;
      RD_C:    state_next = STREAM;
      STREAM:  if (m_beat) state_next = (out_cnt == LAST_IDX) ? IDLE : RD_C;
      default: state_next = IDLE;
    endcase
  end

  // RAM address, write data and write strobes per state.
  always_comb begin
    address_a    = '0;
    address_b    = '0;
    address_c    = '0;
    write_data_a = '0;
    write_data_b = '0;
    write_data_c = '0;
    write_en_a   = 1'b0;
    write_en_b   = 1'b0;
    write_en_c   = 1'b0;
    case (state)
      IDLE, LOAD_A: begin
        address_a    = AW'(load_cnt);
        write_en_a   = s_beat;
        write_data_a = s_beat ? s_axis.data : '0;
      end
      LOAD_B: begin
        address_b    = AW'(load_cnt);
        write_en_b   = s_beat;
        write_data_b = s_beat ? s_axis.data : '0;
      end
      MAC: begin
        if (k_cnt < K_END) begin
          address_a = AW'(i_cnt * N_C + k_cnt);
          address_b = AW'(k_cnt * N_C + j_cnt);
        end
      end
      WR_C: begin
        address_c    = AW'(i_cnt * N_C + j_cnt);
        write_en_c   = 1'b1;
        write_data_c = acc;
      end
      RD_C:    address_c = AW'(out_cnt);
      default: ;
    endcase
  end

  // Load, element (i,j,k) and output counters plus the accumulator.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      load_cnt <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      k_cnt    <= '0;
      out_cnt  <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE, LOAD_A, LOAD_B: begin
          if (s_beat) load_cnt <= (load_cnt == LAST_IDX) ? '0 : load_cnt + ONE;
        end
        MAC: begin
          // Read data lags the address by one cycle, so step k=0 only clears.
          k_cnt <= k_cnt + ONE;
          acc   <= (k_cnt == '0) ? '0 : acc + read_data_a * read_data_b;
        end
        WR_C: begin
          k_cnt <= '0;
          if (j_cnt == LAST_ROW) begin
            j_cnt <= '0;
            i_cnt <= (i_cnt == LAST_ROW) ? '0 : i_cnt + ONE;
          end else begin
            j_cnt <= j_cnt + ONE;
          end
        end
        STREAM: begin
          if (m_beat) out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  // Source ready, sticky framing error and result-data capture.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s_ready     <= 1'b0;
      err         <= 1'b0;
      first_cycle <= 1'b0;
      hold_data   <= '0;
    end else begin
      s_ready     <= (state_next == IDLE) || (state_next == LOAD_A) || (state_next == LOAD_B);
      first_cycle <= (state == RD_C);
      if (first_cycle) hold_data <= read_data_c;
      if (s_beat && (s_axis.last != last_b_word)) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_controller.sv
// ============================================================================
// Module      : tb_matmul_controller
// Description : Directed bench for matmul_controller with N=2 and N=4
//               instances, behavioural synchronous RAMs and stream drivers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  matmul_controller_if #(.DW(32)) s2 ();
  matmul_controller_if #(.DW(32)) m2 ();
  matmul_controller_if #(.DW(32)) s4 ();
  matmul_controller_if #(.DW(32)) m4 ();

  logic [9:0]  aa2, ab2, ac2, aa4, ab4, ac4;
  logic [31:0] wda2, wdb2, wdc2, wda4, wdb4, wdc4;
  logic [31:0] rda2, rdb2, rdc2, rda4, rdb4, rdc4;
  logic        wea2, web2, wec2, wea4, web4, wec4;
  logic        busy2, err2, busy4, err4;

  matmul_controller #(.N(2), .DW(32), .AW(10)) dut2 (
    .CLK(clk), .RESET(rst_n), .s_axis(s2), .m_axis(m2),
    .address_a(aa2), .address_b(ab2), .address_c(ac2),
    .write_data_a(wda2), .write_data_b(wdb2), .write_data_c(wdc2),
    .write_en_a(wea2), .write_en_b(web2), .write_en_c(wec2),
    .read_data_a(rda2), .read_data_b(rdb2), .read_data_c(rdc2),
    .busy(busy2), .err(err2)
  );

  matmul_controller #(.N(4), .DW(32), .AW(10)) dut4 (
    .CLK(clk), .RESET(rst_n), .s_axis(s4), .m_axis(m4),
    .address_a(aa4), .address_b(ab4), .address_c(ac4),
    .write_data_a(wda4), .write_data_b(wdb4), .write_data_c(wdc4),
    .write_en_a(wea4), .write_en_b(web4), .write_en_c(wec4),
    .read_data_a(rda4), .read_data_b(rdb4), .read_data_c(rdc4),
    .busy(busy4), .err(err4)
  );

  // Synchronous RAMs: read data appears one cycle after the address.
  logic [31:0] ma2 [1024];
  logic [31:0] mb2 [1024];
  logic [31:0] mc2 [1024];
  logic [31:0] ma4 [1024];
  logic [31:0] mb4 [1024];
  logic [31:0] mc4 [1024];
  always @(posedge clk) begin
    if (wea2) ma2[aa2] <= wda2;
    if (web2) mb2[ab2] <= wdb2;
    if (wec2) mc2[ac2] <= wdc2;
    rda2 <= ma2[aa2];
    rdb2 <= mb2[ab2];
    rdc2 <= mc2[ac2];
    if (wea4) ma4[aa4] <= wda4;
    if (web4) mb4[ab4] <= wdb4;
    if (wec4) mc4[ac4] <= wdc4;
    rda4 <= ma4[aa4];
    rdb4 <= mb4[ab4];
    rdc4 <= mc4[ac4];
  end

  // Monitors: write-strobe exclusivity and the N=4 compute window.
  int we_overlap = 0;
  bit mon4_en = 1'b0;
  bit seen_v4 = 1'b0;
  int win4_cycles = 0;
  int wec4_pulses = 0;
  always @(negedge clk) begin
    if (int'(wea2) + int'(web2) + int'(wec2) > 1) we_overlap++;
    if (int'(wea4) + int'(web4) + int'(wec4) > 1) we_overlap++;
    if (mon4_en) begin
      if (m4.valid) seen_v4 = 1'b1;
      if (busy4 && !s4.ready && !m4.valid && !seen_v4) win4_cycles++;
      if (wec4) wec4_pulses++;
    end
  end

  logic [31:0] va2 [4];
  logic [31:0] vb2 [4];
  logic [31:0] exp2 [4];
  logic [31:0] va4 [16];
  logic [31:0] vb4 [16];
  logic [31:0] got_d [16];
  logic        got_l [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset2(input string p);
    check($sformatf("%s_busy", p), busy2, 0);
    check($sformatf("%s_err", p), err2, 0);
    check($sformatf("%s_sready", p), s2.ready, 0);
    check($sformatf("%s_mvalid", p), m2.valid, 0);
    check($sformatf("%s_mlast", p), m2.last, 0);
    check($sformatf("%s_mdata", p), m2.data, 0);
    check($sformatf("%s_we", p), {wea2, web2, wec2}, 0);
    check($sformatf("%s_addr", p), {aa2, ab2, ac2}, 0);
    check($sformatf("%s_wd", p), wda2 | wdb2 | wdc2, 0);
  endtask

  task automatic send2(input int last_pos, input bit rnd);
    int sent = 0;
    int budget = 0;
    bit hs;
    for (int w = 0; w < 8; w++) begin
      if (rnd) begin
        while ($urandom_range(0, 2) == 0) begin
          s2.valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s2.valid = 1'b1;
      if (w < 4) s2.data = va2[w];
      else       s2.data = vb2[w-4];
      s2.last = (w == last_pos) || (w == 7);
      hs = 1'b0;
      while (!hs && budget < 500) begin
        @(negedge clk);
        hs = s2.ready;
        @(posedge clk); #1;
        budget++;
      end
      if (hs) sent++;
    end
    s2.valid = 1'b0;
    s2.last  = 1'b0;
    check("src_words", sent, 8);
  endtask

  task automatic sink2(input bit rnd);
    int got = 0;
    int budget = 0;
    bit stalled = 1'b0;
    logic [31:0] pd;
    logic pl;
    while (got < 4 && budget < 2000) begin
      m2.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m2.valid) begin
        if (stalled) begin
          check("hold_data", m2.data, pd);
          check("hold_last", m2.last, pl);
        end
        if (m2.ready) begin
          got_d[got] = m2.data;
          got_l[got] = m2.last;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = m2.data;
          pl = m2.last;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    m2.ready = 1'b0;
    check("snk_words", got, 4);
  endtask

  task automatic run2(input string name, input int last_pos, input bit rnd);
    fork
      send2(last_pos, rnd);
      sink2(rnd);
    join
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_c%0d", name, i), got_d[i], exp2[i]);
      check($sformatf("%s_last%0d", name, i), got_l[i], (i == 3) ? 1 : 0);
    end
    check($sformatf("%s_busy_end", name), busy2, 0);
    check($sformatf("%s_rdy_end", name), s2.ready, 1);
  endtask

  task automatic send4();
    int sent = 0;
    int budget = 0;
    bit hs;
    for (int w = 0; w < 32; w++) begin
      s4.valid = 1'b1;
      if (w < 16) s4.data = va4[w];
      else        s4.data = vb4[w-16];
      s4.last = (w == 31);
      hs = 1'b0;
      while (!hs && budget < 500) begin
        @(negedge clk);
        hs = s4.ready;
        @(posedge clk); #1;
        budget++;
      end
      if (hs) sent++;
    end
    s4.valid = 1'b0;
    s4.last  = 1'b0;
    check("src4_words", sent, 32);
  endtask

  task automatic sink4();
    int got = 0;
    int budget = 0;
    m4.ready = 1'b1;
    while (got < 16 && budget < 3000) begin
      @(negedge clk);
      if (m4.valid) begin
        got_d[got] = m4.data;
        got_l[got] = m4.last;
        got++;
      end
      @(posedge clk); #1;
      budget++;
    end
    m4.ready = 1'b0;
    check("snk4_words", got, 16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s2.valid = 1'b0; s2.data = '0; s2.last = 1'b0; m2.ready = 1'b0;
    s4.valid = 1'b0; s4.data = '0; s4.last = 1'b0; m4.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset2("rst");
    check("rst4_busy", busy4, 0);
    check("rst4_sready", s4.ready, 0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", s2.ready, 0);
    @(posedge clk); #1;
    check("rdy_after_edge", s2.ready, 1);

    // Basic product, sink always ready.
    va2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb2 = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp2 = '{32'd19, 32'd22, 32'd43, 32'd50};
    run2("basic", 7, 1'b0);
    check("basic_err", err2, 0);

    // Negative operands.
    va2 = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF};
    vb2 = '{32'd3, 32'd4, 32'd5, 32'd6};
    exp2 = '{32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'hFFFFFFFA};
    run2("neg", 7, 1'b0);

    // Products that wrap past DW bits.
    va2 = '{32'h80000000, 32'd0, 32'd0, 32'h80000000};
    vb2 = '{32'd2, 32'd3, 32'd2, 32'd3};
    exp2 = '{32'd0, 32'h80000000, 32'd0, 32'h80000000};
    run2("wrap", 7, 1'b0);

    // Random source gaps and sink back-pressure.
    va2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb2 = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp2 = '{32'd19, 32'd22, 32'd43, 32'd50};
    run2("rnd1", 7, 1'b1);
    run2("rnd2", 7, 1'b1);
    check("rnd_err", err2, 0);

    // Early LAST on the third source beat: sticky error, data unaffected.
    run2("framing", 2, 1'b0);
    check("framing_err", err2, 1);
    repeat (3) @(posedge clk);
    #1;
    check("framing_err_sticky", err2, 1);

    // Reset while computing, then a fresh load.
    m2.ready = 1'b0;
    send2(7, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", busy2, 1);
    check("mid_sready", s2.ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset2("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    va2 = '{32'd2, 32'd0, 32'd1, 32'd1};
    vb2 = '{32'd1, 32'd2, 32'd3, 32'd4};
    exp2 = '{32'd2, 32'd4, 32'd4, 32'd6};
    run2("after_rst", 7, 1'b0);

    // N=4: identity A reproduces B; compute window of 16*(4+2) cycles.
    for (int k = 0; k < 16; k++) begin
      va4[k] = (k % 5 == 0) ? 32'd1 : 32'd0;
      vb4[k] = 32'(k * 37) - 32'd100;
    end
    mon4_en = 1'b1;
    fork
      send4();
      sink4();
    join
    mon4_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("n4_c%0d", k), got_d[k], vb4[k]);
      check($sformatf("n4_last%0d", k), got_l[k], (k == 15) ? 1 : 0);
    end
    // Window covers 96 compute cycles plus the single RD_C cycle before output.
    check("n4_window", win4_cycles, 97);
    check("n4_c_writes", wec4_pulses, 16);
    check("n4_busy_end", busy4, 0);
    check("n4_err", err4, 0);
    check("we_exclusive", we_overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
